// File: rtl/dca_slx_sram_responder.sv
// SLX slave responder backed by an internal word-wide SRAM.
// Accepts read/write request beats on slxq and answers on slxy with read
// data beats or a single write reply. Memory contents survive reset.
module dca_slx_sram_responder #(
    parameter int BW_ADDR    = 32,
    parameter int BW_DATA    = 128,
    parameter int DEPTH      = 256,
    parameter int HAS_BURDEN = 0,
    parameter int BW_BURDEN  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [1:0]             slxqdready,
    input  logic                   slxqvalid,
    input  logic                   slxqlast,
    input  logic                   slxqwrite,
    input  logic [7:0]             slxqlen,
    input  logic [2:0]             slxqsize,
    input  logic [1:0]             slxqburst,
    input  logic [BW_DATA/8-1:0]   slxqwstrb,
    input  logic [BW_DATA-1:0]     slxqwdata,
    input  logic [BW_ADDR-1:0]     slxqaddr,
    input  logic [BW_BURDEN-1:0]   slxqburden,
    input  logic [1:0]             slxydready,
    output logic                   slxyvalid,
    output logic                   slxylast,
    output logic                   slxywreply,
    output logic [1:0]             slxyresp,
    output logic [BW_DATA-1:0]     slxyrdata,
    output logic [BW_BURDEN-1:0]   slxyburden
);

    localparam int         NB          = BW_DATA / 8;
    localparam int         LG_NB       = $clog2(NB);
    localparam int         LG_DEPTH    = $clog2(DEPTH);
    localparam logic [2:0] MAX_SIZE    = 3'(LG_NB);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_WRESP, ST_READ} state_t;

    state_t                 state_q, state_d;
    logic [BW_ADDR-1:0]     addr_q, addr_d;      // address of the next beat
    logic [7:0]             len_q, len_d;
    logic [2:0]             size_q, size_d;
    logic [1:0]             burst_q, burst_d;
    logic [BW_BURDEN-1:0]   burden_q, burden_d;
    logic [8:0]             cnt_q, cnt_d;        // read: beat index, write: beats seen
    logic                   err_q, err_d;        // sticky SLVERR for this transaction
    logic                   valid_q, valid_d;
    logic                   last_q, last_d;
    logic                   wreply_q, wreply_d;
    logic [1:0]             resp_q, resp_d;

    logic [BW_DATA-1:0]     mem [DEPTH];
    logic [BW_DATA-1:0]     rd_word_q;
    logic                   mem_we, mem_re;
    logic [LG_DEPTH-1:0]    mem_wr_idx, mem_rd_idx;

    logic                   acc_rd, acc_wr;
    logic                   size_err_in;
    logic                   wr_err;

    // Byte address to word index; addresses beyond the array wrap silently.
    function automatic logic [LG_DEPTH-1:0] word_idx(input logic [BW_ADDR-1:0] a);
        return LG_DEPTH'(a >> LG_NB);
    endfunction

    // Per-beat address step: FIXED holds, every other burst code increments.
    function automatic logic [BW_ADDR-1:0] beat_step(input logic [2:0] sz, input logic [1:0] bu);
        return (bu == 2'b00) ? '0 : (BW_ADDR'(1) << sz);
    endfunction

    // Request-channel readiness from the state; nothing is accepted during reset
    always_comb begin
        slxqdready = 2'b00;
        if (!rst) begin
            case (state_q)
                ST_IDLE:  slxqdready = 2'b11;
                ST_WRITE: slxqdready = 2'b10;
                default:  slxqdready = 2'b00;
            endcase
        end
    end

    assign acc_rd      = slxqvalid & ~slxqwrite & slxqdready[0];
    assign acc_wr      = slxqvalid &  slxqwrite & slxqdready[1];
    assign size_err_in = (slxqsize > MAX_SIZE);

    // Next-state, transaction bookkeeping and memory port control
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        size_d     = size_q;
        burst_d    = burst_q;
        burden_d   = burden_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        valid_d    = valid_q;
        last_d     = last_q;
        wreply_d   = wreply_q;
        resp_d     = resp_q;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        mem_wr_idx = word_idx(addr_q);
        mem_rd_idx = word_idx(addr_q);
        wr_err     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (acc_rd) begin
                    // First read beat is fetched right away so data is ready next cycle
                    mem_re     = 1'b1;
                    mem_rd_idx = word_idx(slxqaddr);
                    addr_d     = slxqaddr + beat_step(slxqsize, slxqburst);
                    len_d      = slxqlen;
                    size_d     = slxqsize;
                    burst_d    = slxqburst;
                    burden_d   = (HAS_BURDEN != 0) ? slxqburden : '0;
                    cnt_d      = 9'd0;
                    err_d      = size_err_in;
                    valid_d    = 1'b1;
                    last_d     = (slxqlen == 8'd0);
                    wreply_d   = 1'b0;
                    resp_d     = size_err_in ? RESP_SLVERR : RESP_OKAY;
                    state_d    = ST_READ;
                end else if (acc_wr) begin
                    mem_we     = ~size_err_in;
                    mem_wr_idx = word_idx(slxqaddr);
                    addr_d     = slxqaddr + beat_step(slxqsize, slxqburst);
                    len_d      = slxqlen;
                    size_d     = slxqsize;
                    burst_d    = slxqburst;
                    burden_d   = (HAS_BURDEN != 0) ? slxqburden : '0;
                    cnt_d      = 9'd1;
                    err_d      = size_err_in;
                    if (slxqlast) begin
                        wr_err   = size_err_in | (slxqlen != 8'd0);
                        err_d    = wr_err;
                        valid_d  = 1'b1;
                        wreply_d = 1'b1;
                        last_d   = 1'b1;
                        resp_d   = wr_err ? RESP_SLVERR : RESP_OKAY;
                        state_d  = ST_WRESP;
                    end else begin
                        state_d  = ST_WRITE;
                    end
                end
            end

            ST_WRITE: begin
                if (acc_wr) begin
                    // err_q only holds the size error here, which suppresses the write
                    mem_we     = ~err_q;
                    mem_wr_idx = word_idx(addr_q);
                    addr_d     = addr_q + beat_step(size_q, burst_q);
                    cnt_d      = cnt_q + 9'd1;
                    if (slxqlast) begin
                        wr_err   = err_q | (cnt_q != {1'b0, len_q});
                        err_d    = wr_err;
                        valid_d  = 1'b1;
                        wreply_d = 1'b1;
                        last_d   = 1'b1;
                        resp_d   = wr_err ? RESP_SLVERR : RESP_OKAY;
                        state_d  = ST_WRESP;
                    end
                end
            end

            ST_WRESP: begin
                if (slxydready[1]) begin
                    valid_d  = 1'b0;
                    wreply_d = 1'b0;
                    last_d   = 1'b0;
                    resp_d   = RESP_OKAY;
                    err_d    = 1'b0;
                    state_d  = ST_IDLE;
                end
            end

            ST_READ: begin
                if (slxydready[0]) begin
                    if (cnt_q == {1'b0, len_q}) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        resp_d  = RESP_OKAY;
                        err_d   = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        // Fetch the following beat while the current one is taken
                        cnt_d   = cnt_q + 9'd1;
                        mem_re  = 1'b1;
                        addr_d  = addr_q + beat_step(size_q, burst_q);
                        last_d  = ((cnt_q + 9'd1) == {1'b0, len_q});
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // Control and reply registers; everything except the memory array resets
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            size_q   <= '0;
            burst_q  <= '0;
            burden_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            wreply_q <= 1'b0;
            resp_q   <= RESP_OKAY;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            size_q   <= size_d;
            burst_q  <= burst_d;
            burden_q <= burden_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            wreply_q <= wreply_d;
            resp_q   <= resp_d;
        end
    end

    // Byte-enabled write port and registered read port of the word array
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (slxqwstrb[b]) begin
                    mem[mem_wr_idx][b*8 +: 8] <= slxqwdata[b*8 +: 8];
                end
            end
        end
        if (mem_re) begin
            rd_word_q <= mem[mem_rd_idx];
        end
    end

    assign slxyvalid  = valid_q;
    assign slxylast   = last_q;
    assign slxywreply = wreply_q;
    assign slxyresp   = resp_q;
    // Read data only appears on a valid, error-free read beat
    assign slxyrdata  = (valid_q && !wreply_q && !err_q) ? rd_word_q : '0;
    assign slxyburden = valid_q ? burden_q : '0;

endmodule

// File: tb/tb_dca_slx_sram_responder.sv
// Scoreboard bench for dca_slx_sram_responder: expected replies are queued as
// requests are driven and compared as the responder returns them.
module tb_dca_slx_sram_responder;

    localparam int DEPTH = 256;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   slxqdready;
    logic         slxqvalid, slxqlast, slxqwrite;
    logic [7:0]   slxqlen;
    logic [2:0]   slxqsize;
    logic [1:0]   slxqburst;
    logic [15:0]  slxqwstrb;
    logic [127:0] slxqwdata;
    logic [31:0]  slxqaddr;
    logic [0:0]   slxqburden;
    logic [1:0]   slxydready;
    logic         slxyvalid, slxylast, slxywreply;
    logic [1:0]   slxyresp;
    logic [127:0] slxyrdata;
    logic [0:0]   slxyburden;

    dca_slx_sram_responder #(
        .BW_ADDR(32), .BW_DATA(128), .DEPTH(DEPTH), .HAS_BURDEN(0), .BW_BURDEN(1)
    ) dut (
        .clk(clk), .rst(rst), .slxqdready(slxqdready), .slxqvalid(slxqvalid),
        .slxqlast(slxqlast), .slxqwrite(slxqwrite), .slxqlen(slxqlen),
        .slxqsize(slxqsize), .slxqburst(slxqburst), .slxqwstrb(slxqwstrb),
        .slxqwdata(slxqwdata), .slxqaddr(slxqaddr), .slxqburden(slxqburden),
        .slxydready(slxydready), .slxyvalid(slxyvalid), .slxylast(slxylast),
        .slxywreply(slxywreply), .slxyresp(slxyresp), .slxyrdata(slxyrdata),
        .slxyburden(slxyburden)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic         wreply;
        logic         last;
        logic [1:0]   resp;
        logic [127:0] rdata;
    } reply_t;

    reply_t       exp_q[$];
    reply_t       obs_q[$];
    int           stamp_q[$];
    logic [127:0] ref_mem [DEPTH];
    int           checks = 0;
    int           passes = 0;
    int           acc_cyc = 0;

    function automatic string show(input reply_t r);
        return $sformatf("w=%0b l=%0b r=%0d d=%h", r.wreply, r.last, r.resp, r.rdata);
    endfunction

    function automatic reply_t cur();
        reply_t r;
        r.wreply = slxywreply;
        r.last   = slxylast;
        r.resp   = slxyresp;
        r.rdata  = slxyrdata;
        return r;
    endfunction

    function automatic logic [7:0] widx(input logic [31:0] a);
        return a[11:4];
    endfunction

    function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [2:0] sz,
                                              input logic [1:0] bu, input int i);
        return (bu == 2'b00) ? a : a + (32'(i) << sz);
    endfunction

    task automatic idle_inputs();
        slxqvalid = 0; slxqlast = 0; slxqwrite = 0; slxqlen = 0; slxqsize = 0;
        slxqburst = 0; slxqwstrb = 0; slxqwdata = 0; slxqaddr = 0; slxqburden = 0;
    endtask

    // Present one request beat and hold it until the matching ready bit takes it
    task automatic send_beat(input logic wr, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input logic last,
                             input logic [15:0] strb, input logic [127:0] data);
        bit acc = 0;
        slxqvalid = 1; slxqwrite = wr; slxqaddr = addr; slxqlen = len; slxqsize = size;
        slxqburst = burst; slxqlast = last; slxqwstrb = strb; slxqwdata = data;
        for (int t = 0; t < 100 && !acc; t++) begin
            if (wr ? slxqdready[1] : slxqdready[0]) begin
                acc = 1;
                acc_cyc = cyc;
            end
            @(posedge clk); #1;
        end
        if (!acc) begin
            checks++;
            $display("FAIL accept_timeout: request wr=%0b addr=%h never accepted", wr, addr);
        end
    endtask

    // Drive nbeats write beats (data base+i); model memory and queue the reply
    task automatic write_burst(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                               input logic [1:0] burst, input int nbeats, input logic [15:0] strb,
                               input logic [127:0] base);
        reply_t e;
        for (int i = 0; i < nbeats; i++) begin
            logic [127:0] d = base + 128'(i);
            logic [7:0]   w = widx(beat_addr(addr, size, burst, i));
            if (size <= 3'd4) begin
                for (int b = 0; b < 16; b++) if (strb[b]) ref_mem[w][b*8 +: 8] = d[b*8 +: 8];
            end
            send_beat(1'b1, addr, len, size, burst, (i == nbeats - 1), strb, d);
        end
        idle_inputs();
        e.wreply = 1; e.last = 1; e.rdata = '0;
        e.resp = (size > 3'd4 || nbeats != int'(len) + 1) ? 2'b10 : 2'b00;
        exp_q.push_back(e);
    endtask

    // Issue a read request and queue the len+1 expected data beats
    task automatic read_req(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst);
        reply_t e;
        send_beat(1'b0, addr, len, size, burst, 1'b0, 16'h0, '0);
        idle_inputs();
        for (int i = 0; i <= int'(len); i++) begin
            e.wreply = 0;
            e.last   = (i == int'(len));
            e.resp   = (size > 3'd4) ? 2'b10 : 2'b00;
            e.rdata  = (size > 3'd4) ? '0 : ref_mem[widx(beat_addr(addr, size, burst, i))];
            exp_q.push_back(e);
        end
    endtask

    // Record n reply beats as they handshake, with the cycle each was seen
    task automatic collect(input int n, input logic [1:0] rdy);
        int got = 0;
        int t = 0;
        stamp_q.delete();
        slxydready = rdy;
        while (got < n && t < 200) begin
            if (slxyvalid && ((slxywreply && rdy[1]) || (!slxywreply && rdy[0]))) begin
                obs_q.push_back(cur());
                stamp_q.push_back(cyc);
                got++;
                if (slxylast) $display("txn: %s reply resp=%0d", slxywreply ? "write" : "read", slxyresp);
            end
            @(posedge clk); #1;
            t++;
        end
        slxydready = 2'b00;
        if (got < n) begin
            checks++;
            $display("FAIL reply_timeout: got %0d beats, want %0d", got, n);
        end
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (slxqdready !== 2'b00) $display("FAIL reset_qdready: got %b want 00", slxqdready);
        else passes++;
        checks++;
        if ({slxyvalid, slxylast, slxywreply, slxyresp, slxyrdata, slxyburden} !== '0)
            $display("FAIL reset_outputs: got v=%b l=%b w=%b r=%b d=%h b=%b want all 0",
                     slxyvalid, slxylast, slxywreply, slxyresp, slxyrdata, slxyburden);
        else passes++;
        rst = 0;
        @(posedge clk); #1;
        checks++;
        if (slxqdready !== 2'b11) $display("FAIL reset_release: got %b want 11", slxqdready);
        else passes++;
    endtask

    task automatic test_single();
        reply_t o, e;
        write_burst(32'h40, 8'd0, 3'd4, 2'b01, 1, 16'hFFFF, 128'h00112233_44556677_8899AABB_CCDDEEFF);
        checks++;
        if (slxyvalid !== 1'b1 || slxywreply !== 1'b1 || cyc - acc_cyc != 1)
            $display("FAIL wresp_latency: got valid=%b wreply=%b lat=%0d want 1 1 1", slxyvalid, slxywreply, cyc - acc_cyc);
        else passes++;
        slxydready = 2'b01;   // read-data ready must not retire a write reply
        @(posedge clk); #1;
        checks++;
        if (slxyvalid !== 1'b1 || slxywreply !== 1'b1)
            $display("FAIL wrong_ready: got valid=%b wreply=%b want 1 1", slxyvalid, slxywreply);
        else passes++;
        collect(1, 2'b10);
        checks++;
        if (slxqdready !== 2'b11 || slxyvalid !== 1'b0)
            $display("FAIL turnaround: got qdready=%b valid=%b want 11 0", slxqdready, slxyvalid);
        else passes++;
        read_req(32'h40, 8'd0, 3'd4, 2'b01);
        collect(1, 2'b01);
        checks++;
        if (stamp_q.size() != 1 || stamp_q[0] - acc_cyc != 1)
            $display("FAIL read_latency: got %0d want 1", (stamp_q.size() != 0) ? stamp_q[0] - acc_cyc : -1);
        else passes++;
        checks++;
        if (obs_q.size() < 2 || obs_q[1].rdata !== 128'h00112233_44556677_8899AABB_CCDDEEFF)
            $display("FAIL single_data: got %h want 00112233445566778899aabbccddeeff",
                     (obs_q.size() > 1) ? obs_q[1].rdata : 128'h0);
        else passes++;
        while (obs_q.size() != 0 && exp_q.size() != 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (o !== e) $display("FAIL single_sb: got %s want %s", show(o), show(e));
            else passes++;
        end
    endtask

    task automatic test_incr();
        reply_t o, e, snap;
        write_burst(32'h100, 8'd3, 3'd4, 2'b01, 4, 16'hFFFF, 128'd1);
        collect(1, 2'b10);
        read_req(32'h100, 8'd3, 3'd4, 2'b01);
        collect(4, 2'b01);
        for (int i = 0; i < 4 && i < stamp_q.size(); i++) begin
            checks++;
            if (stamp_q[i] - acc_cyc != i + 1)
                $display("FAIL incr_timing: beat %0d at +%0d want +%0d", i, stamp_q[i] - acc_cyc, i + 1);
            else passes++;
        end
        for (int i = 0; i < 4 && i + 1 < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i + 1].rdata !== 128'(i + 1) || obs_q[i + 1].last !== (i == 3))
                $display("FAIL incr_data: beat %0d got d=%h l=%b want d=%0d l=%b",
                         i, obs_q[i + 1].rdata, obs_q[i + 1].last, i + 1, i == 3);
            else passes++;
        end
        // Same read with a one-cycle stall on beat 2
        read_req(32'h100, 8'd3, 3'd4, 2'b01);
        slxydready = 2'b01;
        obs_q.push_back(cur());
        @(posedge clk); #1;
        slxydready = 2'b00;
        snap = cur();
        @(posedge clk); #1;
        checks++;
        if (cur() !== snap || slxyvalid !== 1'b1 || snap.rdata !== 128'd2)
            $display("FAIL stall_hold: got %s v=%b want %s with data 2", show(cur()), slxyvalid, show(snap));
        else passes++;
        collect(3, 2'b01);
        while (obs_q.size() != 0 && exp_q.size() != 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (o !== e) $display("FAIL incr_sb: got %s want %s", show(o), show(e));
            else passes++;
        end
    endtask

    task automatic test_fixed();
        reply_t o, e;
        write_burst(32'h20, 8'd0, 3'd4, 2'b01, 1, 16'hFFFF, 128'hDEAD_BEEF_0000_0002);
        collect(1, 2'b10);
        read_req(32'h20, 8'd2, 3'd4, 2'b00);
        collect(3, 2'b01);
        for (int i = 1; i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i].rdata !== 128'hDEAD_BEEF_0000_0002)
                $display("FAIL fixed_data: beat %0d got %h want deadbeef00000002", i - 1, obs_q[i].rdata);
            else passes++;
        end
        while (obs_q.size() != 0 && exp_q.size() != 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (o !== e) $display("FAIL fixed_sb: got %s want %s", show(o), show(e));
            else passes++;
        end
    endtask

    task automatic test_strb();
        reply_t o, e;
        write_burst(32'h300, 8'd0, 3'd4, 2'b01, 1, 16'hFFFF, {16{8'h55}});
        collect(1, 2'b10);
        write_burst(32'h300, 8'd0, 3'd4, 2'b01, 1, 16'h000F, {16{8'hAA}});
        collect(1, 2'b10);
        read_req(32'h300, 8'd0, 3'd4, 2'b01);
        collect(1, 2'b01);
        checks++;
        if (obs_q.size() < 3 || obs_q[2].rdata !== {{12{8'h55}}, {4{8'hAA}}})
            $display("FAIL strb_merge: got %h want 5555...55aaaaaaaa", (obs_q.size() > 2) ? obs_q[2].rdata : 128'h0);
        else passes++;
        while (obs_q.size() != 0 && exp_q.size() != 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (o !== e) $display("FAIL strb_sb: got %s want %s", show(o), show(e));
            else passes++;
        end
    endtask

    task automatic test_errors();
        reply_t o, e;
        // Oversized beat: SLVERR and memory untouched
        write_burst(32'h200, 8'd0, 3'd4, 2'b01, 1, 16'hFFFF, 128'h1234_5678);
        collect(1, 2'b10);
        write_burst(32'h200, 8'd0, 3'd5, 2'b01, 1, 16'hFFFF, 128'hBAD);
        collect(1, 2'b10);
        checks++;
        if (obs_q.size() < 2 || obs_q[1].resp !== 2'b10)
            $display("FAIL size_err_resp: got %0d want 2", (obs_q.size() > 1) ? obs_q[1].resp : 2'b00);
        else passes++;
        read_req(32'h200, 8'd0, 3'd4, 2'b01);
        collect(1, 2'b01);
        checks++;
        if (obs_q.size() < 3 || obs_q[2].rdata !== 128'h1234_5678)
            $display("FAIL size_err_mem: got %h want 12345678", (obs_q.size() > 2) ? obs_q[2].rdata : 128'h0);
        else passes++;
        // len=3 but last on beat 2: SLVERR right after beat 2, data still written
        write_burst(32'h400, 8'd3, 3'd4, 2'b01, 2, 16'hFFFF, 128'h70);
        collect(1, 2'b10);
        checks++;
        if (stamp_q.size() != 1 || stamp_q[0] - acc_cyc != 1)
            $display("FAIL short_wr_timing: reply at +%0d want +1", (stamp_q.size() != 0) ? stamp_q[0] - acc_cyc : -1);
        else passes++;
        read_req(32'h400, 8'd1, 3'd4, 2'b01);
        collect(2, 2'b01);
        // Address past the array wraps onto word 1
        write_burst(32'h10, 8'd0, 3'd4, 2'b01, 1, 16'hFFFF, 128'h0F0F_0001);
        collect(1, 2'b10);
        read_req(32'(DEPTH * 16 + 16), 8'd0, 3'd4, 2'b01);
        collect(1, 2'b01);
        checks++;
        if (obs_q[obs_q.size() - 1].rdata !== 128'h0F0F_0001)
            $display("FAIL wrap_read: got %h want 0f0f0001", obs_q[obs_q.size() - 1].rdata);
        else passes++;
        // Oversized read beat: SLVERR with zero data
        read_req(32'h40, 8'd0, 3'd5, 2'b01);
        collect(1, 2'b01);
        while (obs_q.size() != 0 && exp_q.size() != 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (o !== e) $display("FAIL err_sb: got %s want %s", show(o), show(e));
            else passes++;
        end
    endtask

    task automatic test_mid_reset();
        reply_t o, e;
        send_beat(1'b0, 32'h100, 8'd7, 3'd4, 2'b00, 1'b0, 16'h0, '0);
        idle_inputs();
        checks++;
        if (slxyvalid !== 1'b1 || slxyrdata !== 128'd1 || slxylast !== 1'b0)
            $display("FAIL abort_beat1: got v=%b d=%h l=%b want 1 1 0", slxyvalid, slxyrdata, slxylast);
        else passes++;
        slxydready = 2'b01;
        @(posedge clk); #1;
        rst = 1;
        slxydready = 2'b00;
        checks++;
        if (slxqdready !== 2'b00) $display("FAIL abort_qdready_rst: got %b want 00", slxqdready);
        else passes++;
        @(posedge clk); #1;
        checks++;
        if ({slxyvalid, slxylast, slxywreply, slxyresp, slxyrdata, slxyburden, slxqdready} !== '0)
            $display("FAIL abort_outputs: got v=%b l=%b w=%b r=%b d=%h qd=%b want all 0",
                     slxyvalid, slxylast, slxywreply, slxyresp, slxyrdata, slxqdready);
        else passes++;
        rst = 0;
        @(posedge clk); #1;
        checks++;
        if (slxqdready !== 2'b11 || slxyvalid !== 1'b0)
            $display("FAIL abort_recover: got qdready=%b valid=%b want 11 0", slxqdready, slxyvalid);
        else passes++;
        read_req(32'h100, 8'd1, 3'd4, 2'b01);
        collect(2, 2'b01);
        while (obs_q.size() != 0 && exp_q.size() != 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (o !== e) $display("FAIL abort_sb: got %s want %s", show(o), show(e));
            else passes++;
        end
    endtask

    initial begin
        idle_inputs();
        slxydready = 2'b00;
        test_reset();
        test_single();
        test_incr();
        test_fixed();
        test_strb();
        test_errors();
        test_mid_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
